// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and helpers for the branch resolve unit: branch kinds, predictor
// modes, the default update-queue entry layout and the saturating-counter helper.
package RVS192_package;

  typedef enum logic [2:0] {
    BR_EQ  = 3'd0,
    BR_NE  = 3'd1,
    BR_LT  = 3'd2,
    BR_GE  = 3'd3,
    BR_LTU = 3'd4,
    BR_GEU = 3'd5
  } br_kind_e;

  localparam int BP_LOCAL  = 0;
  localparam int BP_GSHARE = 1;
  localparam int BP_HYBRID = 2;

  localparam int BR_IDX_W     = 8;
  localparam int BR_CNT_W     = 2;
  localparam int BR_CNT_MAX_W = 8;

  typedef struct packed {
    logic [BR_IDX_W-1:0] index;
    logic [BR_CNT_W-1:0] lcnt;
    logic [BR_CNT_W-1:0] gcnt;
    logic [BR_CNT_W-1:0] chooser;
    logic                taken;
  } br_upd_t;

  // Counter of width w (<= BR_CNT_MAX_W) held in the low bits of cnt.
  function automatic logic [BR_CNT_MAX_W-1:0] sat_update(
    input logic [BR_CNT_MAX_W-1:0] cnt,
    input logic                    up,
    input logic                    set_max,
    input int unsigned             w = BR_CNT_W
  );
    logic [BR_CNT_MAX_W:0]   max_w;
    logic [BR_CNT_MAX_W-1:0] max;
    max_w = ({{BR_CNT_MAX_W{1'b0}}, 1'b1} << w) - {{BR_CNT_MAX_W{1'b0}}, 1'b1};
    max   = max_w[BR_CNT_MAX_W-1:0];
    if (set_max)          return max;
    else if (up)          return (cnt == max) ? cnt : cnt + 8'd1;
    else                  return (cnt == '0)  ? cnt : cnt - 8'd1;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_update_queue.sv
// Synchronous FIFO of predictor updates. A separate count register tells full
// from empty; push on a full queue is accepted only together with a pop.
module br_update_queue
  import RVS192_package::*;
#(
  parameter type T     = br_upd_t,
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  T                 din,
  input  logic             pop,
  output T                 dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: outcome/target check, registered redirect and GHR
// repair, predictor update queue. Optional statistics under `BR_STATS_EN.
module branch_resolve_unit
  import RVS192_package::*;
#(
  parameter int PC_W     = 32,
  parameter int CNT_W    = 2,
  parameter int GHR_W    = 8,
  parameter int IDX_W    = 8,
  parameter int UQ_DEPTH = 4,
  parameter int BP_MODE  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_branch,
  input  logic              ex_uncond,
  input  logic [2:0]        ex_kind,
  input  logic              eq,
  input  logic              lt,
  input  logic              ltu,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic [PC_W-1:0]   ex_imm,
  input  logic [PC_W-1:0]   ex_jump_target,
  input  logic              ex_pred_taken,
  input  logic [PC_W-1:0]   ex_pred_target,
  input  logic [CNT_W-1:0]  ex_lcnt,
  input  logic [CNT_W-1:0]  ex_gcnt,
  input  logic [CNT_W-1:0]  ex_chooser,
  input  logic [GHR_W-1:0]  ex_ghr,
  input  logic [IDX_W-1:0]  ex_index,
  output logic              stall,
  output logic              redirect_valid,
  output logic [PC_W-1:0]   redirect_pc,
  output logic              ghr_repair_valid,
  output logic [GHR_W-1:0]  ghr_repair,
  output logic              upd_valid,
  input  logic              upd_ready,
  output logic [IDX_W-1:0]  upd_index,
  output logic [CNT_W-1:0]  upd_lcnt,
  output logic [CNT_W-1:0]  upd_gcnt,
  output logic [CNT_W-1:0]  upd_chooser,
  output logic              upd_taken,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispred
);

  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic [CNT_W-1:0] lcnt;
    logic [CNT_W-1:0] gcnt;
    logic [CNT_W-1:0] chooser;
    logic             taken;
  } upd_t;

  localparam int QC_W = $clog2(UQ_DEPTH) + 1;

  logic            res, cond, actual, wrong;
  logic [PC_W-1:0] next_pc;
  logic            uq_full, uq_empty;
  logic [QC_W-1:0] unused_uq_count;
  upd_t            push_ent, head;
  logic [BR_CNT_MAX_W-1:0] l_in, g_in, c_in, l_sat, g_sat, c_sat;
  logic [CNT_W-1:0] l_new, g_new, c_new;

  assign stall = uq_full & ~upd_ready;
  assign res   = ex_valid & ex_branch & ~stall;

  always_comb begin
    case (br_kind_e'(ex_kind))
      BR_EQ:   cond = eq;
      BR_NE:   cond = ~eq;
      BR_LT:   cond = lt;
      BR_GE:   cond = ~lt;
      BR_LTU:  cond = ltu;
      BR_GEU:  cond = ~ltu;
      default: cond = 1'b0;
    endcase
  end

  assign actual  = ex_uncond | cond;
  assign next_pc = ex_uncond ? ex_jump_target
                 : actual    ? ex_pc + ex_imm
                 :             ex_pc + PC_W'(4);
  assign wrong   = (actual != ex_pred_taken) | (actual & (next_pc != ex_pred_target));

  always_comb begin
    l_in = '0;
    g_in = '0;
    c_in = '0;
    l_in[CNT_W-1:0] = ex_lcnt;
    g_in[CNT_W-1:0] = ex_gcnt;
    c_in[CNT_W-1:0] = ex_chooser;
    l_sat = sat_update(l_in, actual, ex_uncond, CNT_W);
    g_sat = sat_update(g_in, actual, ex_uncond, CNT_W);
    // Chooser trains only when the two predictors disagree; +1 favours gshare.
    if (ex_uncond)
      c_sat = sat_update(c_in, 1'b1, 1'b1, CNT_W);
    else if (ex_lcnt[CNT_W-1] != ex_gcnt[CNT_W-1])
      c_sat = sat_update(c_in, ex_gcnt[CNT_W-1] == actual, 1'b0, CNT_W);
    else
      c_sat = c_in;
    l_new = l_sat[CNT_W-1:0];
    g_new = g_sat[CNT_W-1:0];
    c_new = c_sat[CNT_W-1:0];
    if (BP_MODE == BP_LOCAL) begin
      g_new = ex_gcnt;
      c_new = ex_chooser;
    end else if (BP_MODE == BP_GSHARE) begin
      l_new = ex_lcnt;
      c_new = ex_chooser;
    end
  end

  assign push_ent = '{index: ex_index, lcnt: l_new, gcnt: g_new, chooser: c_new, taken: actual};

  br_update_queue #(.T(upd_t), .DEPTH(UQ_DEPTH)) u_uq (
    .clk   (clk),
    .rst   (rst),
    .push  (res),
    .din   (push_ent),
    .pop   (upd_ready),
    .dout  (head),
    .full  (uq_full),
    .empty (uq_empty),
    .count (unused_uq_count)
  );

  assign upd_valid   = ~uq_empty;
  assign upd_index   = head.index;
  assign upd_lcnt    = head.lcnt;
  assign upd_gcnt    = head.gcnt;
  assign upd_chooser = head.chooser;
  assign upd_taken   = head.taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid   <= 1'b0;
      ghr_repair_valid <= 1'b0;
      redirect_pc      <= '0;
      ghr_repair       <= '0;
    end else begin
      redirect_valid   <= res & wrong;
      ghr_repair_valid <= res & wrong;
      if (res & wrong) begin
        redirect_pc <= next_pc;
        ghr_repair  <= {ex_ghr[GHR_W-2:0], actual};
      end
    end
  end

`ifdef BR_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else if (res) begin
      stat_branches <= stat_branches + 32'd1;
      if (wrong) stat_mispred <= stat_mispred + 32'd1;
    end
  end
`else
  assign stat_branches = '0;
  assign stat_mispred  = '0;
`endif

endmodule
